// File: rtl/data_mem_hs_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_hs_if
// Brief    : Request/response handshake bundle for the data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_hs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_hs
// Brief    : MEM-stage data memory, valid/ready handshake, 1-cycle registered
//            read, fault detection and a post-reset zero sweep.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_hs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 2048
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    data_mem_hs_if.slave bus,
    output logic         init_done
);
    localparam int c_BYTES  = DATA_WIDTH / 8;
    localparam int c_LANE_W = $clog2(c_BYTES);
    localparam int c_IDX_W  = $clog2(MEM_WORDS);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    state_t                r_state;
    logic [c_IDX_W-1:0]    r_cnt;
    logic                  r_init_done;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_fault;

    logic [c_LANE_W-1:0]   w_lane;
    logic [c_IDX_W-1:0]    w_idx;
    logic [1:0]            w_size;
    logic                  w_oor;
    logic                  w_misalign;
    logic                  w_illegal;
    logic                  w_fault;
    logic                  w_req_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH-1:0] w_load;
    logic [c_BYTES-1:0]    w_size_mask;
    logic [c_BYTES-1:0]    w_byte_en;
    logic [DATA_WIDTH-1:0] w_bit_mask;
    logic [DATA_WIDTH-1:0] w_wshift;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_lane = bus.req_addr[c_LANE_W-1:0];
    assign w_idx  = bus.req_addr[c_LANE_W +: c_IDX_W];
    assign w_size = bus.req_funct3[1:0];
    // Any address bit above the memory span makes the access out of range.
    assign w_oor  = |(bus.req_addr >> (c_LANE_W + c_IDX_W));

    always_comb begin
        case (w_size)
            2'd1:    w_misalign = bus.req_addr[0];
            2'd2:    w_misalign = |bus.req_addr[1:0];
            2'd3:    w_misalign = |bus.req_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_illegal = (bus.req_funct3 == 3'b111)
                     || ((DATA_WIDTH == 32) && ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110)))
                     || (bus.req_we && bus.req_funct3[2]);
    assign w_fault   = w_illegal | w_misalign | w_oor;

    assign w_req_ready = (r_state == S_RUN) && (!r_resp_valid || bus.resp_ready);
    assign w_accept    = bus.req_valid && w_req_ready;

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};

    always_comb begin
        case (bus.req_funct3)
            3'b000:  w_load = DATA_WIDTH'($signed(w_shift[7:0]));
            3'b001:  w_load = DATA_WIDTH'($signed(w_shift[15:0]));
            3'b010:  w_load = DATA_WIDTH'($signed(w_shift[31:0]));
            3'b011:  w_load = w_shift;
            3'b100:  w_load = DATA_WIDTH'(w_shift[7:0]);
            3'b101:  w_load = DATA_WIDTH'(w_shift[15:0]);
            3'b110:  w_load = DATA_WIDTH'(w_shift[31:0]);
            default: w_load = '0;
        endcase
    end

    always_comb begin
        case (w_size)
            2'd0:    w_size_mask = c_BYTES'(8'h01);
            2'd1:    w_size_mask = c_BYTES'(8'h03);
            2'd2:    w_size_mask = c_BYTES'(8'h0F);
            default: w_size_mask = c_BYTES'(8'hFF);
        endcase
    end

    assign w_byte_en = w_size_mask << w_lane;
    assign w_wshift  = bus.req_wdata << {w_lane, 3'b000};

    always_comb begin
        w_bit_mask = '0;
        for (int b = 0; b < c_BYTES; b++) begin
            w_bit_mask[b*8 +: 8] = {8{w_byte_en[b]}};
        end
    end

    assign w_merged = (w_word & ~w_bit_mask) | (w_wshift & w_bit_mask);

    // Storage has no reset; contents become defined through the INIT sweep.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_accept && bus.req_we && !w_fault) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_INIT;
            r_cnt        <= '0;
            r_init_done  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_cnt <= r_cnt + c_IDX_W'(1);
                    if (r_cnt == c_IDX_W'(MEM_WORDS - 1)) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_resp_valid <= 1'b1;
                        r_resp_fault <= w_fault;
                        r_resp_rdata <= (w_fault || bus.req_we) ? '0 : w_load;
                    end else if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_fault = r_resp_fault;
    assign init_done      = r_init_done;
endmodule
`default_nettype wire

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
- Next-generation data memory for the pipelined CPU's MEM stage.
- Generalised to 32- or 64-bit data with RV64 LD/LWU/SD support, a valid/ready request/response handshake, and a registered read with 1-cycle latency.
- Flags misaligned, out-of-range and illegal accesses instead of silently corrupting memory.
- Runs a post-reset clear sweep so memory contents are deterministic.

Parameters:
- DATA_WIDTH, 32, data width; only 32 or 64 are legal.
- ADDR_WIDTH, 32, byte-address width.
- MEM_WORDS, 2048, number of DATA_WIDTH-bit words; must be a power of 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  response register holds a result.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_WIDTH  load result, sign- or zero-extended; 0 for stores and faults.
- resp_fault  out  1  access faulted.
- init_done  out  1  clear sweep complete.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=INIT, clear counter=0.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_fault=0, init_done=0.
- INIT state:
  - Writes 0 to word[cnt] each cycle, cnt++.
  - After word MEM_WORDS-1 is written: state goes to RUN and init_done=1 on the next cycle. Sweep takes exactly MEM_WORDS cycles.
  - req_ready=0 throughout INIT.
- RUN state: req_ready = !resp_valid || resp_ready, i.e. a single-entry response register with full-throughput pass-through.
- Accept and response timing:
  - A request is accepted when req_valid && req_ready.
  - Its response appears on the next edge: resp_valid=1 with resp_rdata/resp_fault.
  - resp_valid clears when resp_ready=1 and no new request is accepted in the same cycle.
- Indexing:
  - Word index = req_addr >> log2(DATA_WIDTH/8).
  - Byte lane = low log2(DATA_WIDTH/8) address bits.
- Loads:
  - 000 LB, 001 LH, 010 LW: sign-extended to DATA_WIDTH.
  - 100 LBU, 101 LHU: zero-extended.
  - DATA_WIDTH=64 only: 011 LD; 110 LWU zero-extended.
  - A sub-word is selected by lane, little-endian.
- Stores:
  - 000 SB, 001 SH, 010 SW; 011 SD when DATA_WIDTH=64.
  - Only the addressed byte lanes are written; other lanes are unchanged.
  - Store response: resp_rdata=0, resp_fault=0.
- Fault conditions (any one sets resp_fault=1, resp_rdata=0, and suppresses the memory write):
  - Misaligned: halfword with addr[0]!=0; word with addr[1:0]!=0; doubleword with addr[2:0]!=0.
  - Out of range: word index >= MEM_WORDS, i.e. any address bit above the memory span is set.
  - Illegal funct3: 111; 011 or 110 when DATA_WIDTH=32; store funct3 > 3.
- Ordering:
  - A load accepted the cycle after a store to the same word returns the stored data.
  - Read is synchronous and write-first, so back-to-back store then load is coherent.
- Stall: while resp_valid=1 and resp_ready=0, the response holds stable and nothing is accepted.
- Reset mid-operation:
  - A pending response is dropped and the sweep restarts from word 0.
  - Memory contents are not guaranteed until init_done=1.

Test Plan:
- Reset release with MEM_WORDS=16 -> req_ready=0 and init_done=0 for 16 cycles; init_done=1 and req_ready=1 on cycle 17; LW @0x3C returns 0.
- SW 0x8001_F0FF @0x10, then LB @0x10, LBU @0x11, LH @0x12, LHU @0x12, each 1 cycle apart -> 0xFFFFFFFF, 0x000000F0, 0xFFFF8001, 0x00008001, all resp_fault=0.
- SB 0xAA @0x21 onto word 0x11223344 @0x20 -> LW @0x20 = 0x1122AA44; SH 0xBEEF @0x22 -> LW = 0xBEEFAA44.
- Faults:
  - LH @0x13 -> resp_fault=1, resp_rdata=0.
  - SW 0xDEAD @0x22 -> fault, and a following LW @0x20 is unchanged.
  - LW @ MEM_WORDS*4 -> fault.
  - funct3 111 -> fault.
- Backpressure: resp_ready=0 for 3 cycles with req_valid held -> req_ready=0 and the response stable; on resp_ready=1, exactly one new request is accepted per cycle with no loss or duplication.
- DATA_WIDTH=64: SD 0x8000_0000_FFFF_FFFF @0x8 -> LD returns it, LW @0x8 = 0xFFFF_FFFF_FFFF_FFFF, LWU @0x8 = 0x0000_0000_FFFF_FFFF, LWU @0xC = 0x0000_0000_8000_0000.
